sseg_scan_ctrl: RTL



---
 rtl/sseg_scan_ctrl.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/sseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sseg_scan_ctrl
//
// Multiplexed common-anode seven-segment display controller. Scans NUM_DIGITS
// digits, one slot of SCAN_DIV clocks per digit, with 16-step PWM brightness,
// an all-anodes-off dead time at the start of every slot (anti-ghosting) and
// a double-buffered display image that is only swapped at frame boundaries.
//
// Optional feature macro: SSEG_HEX_DECODE_EN
//   defined   : hex_mode selects hex_in nibbles through a hex-to-segment table
//   undefined : hex_in / hex_mode are ignored; raw seg_in is always shown
//
// Ports
//   app_clk, app_arst : clock, asynchronous active-high reset
//   enable            : 1 = scan, 0 = dark (counters held at 0)
//   seg_in            : raw segments, digit i = [7i+6:7i], bit6 = A .. bit0 = G
//   hex_in, hex_mode  : hex nibble per digit and its select
//   dots_in, blank_in : per-digit decimal point / force-dark
//   brightness        : PWM level 0..15, used live (not buffered)
//   update_req        : strobe, captures the display inputs into the pending
//                       buffer
//   update_ack        : pulse when pending has been copied to active
//   A_TO_G_out, DOTS_out, AN_out : pins (segments high, anodes low active)
//   frame_done        : pulse after the last digit slot of a frame
// -----------------------------------------------------------------------------
module sseg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEAD_CYC   = 64
) (
  input  logic                    app_clk,
  input  logic                    app_arst,
  input  logic                    enable,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic                    hex_mode,
  input  logic [NUM_DIGITS-1:0]   dots_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [3:0]              brightness,
  input  logic                    update_req,
  output logic                    update_ack,
  output logic [6:0]              A_TO_G_out,
  output logic                    DOTS_out,
  output logic [NUM_DIGITS-1:0]   AN_out,
  output logic                    frame_done
);

  // A slot is 16 PWM phases of PH_LEN clocks. The prescaler is kept as the
  // pair (phase, sub) so no divider is needed to derive the PWM phase.
  localparam int PH_LEN = SCAN_DIV / 16;
  localparam int SW     = (PH_LEN > 1) ? $clog2(PH_LEN) : 1;
  localparam int IW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(PH_LEN - 1);
  // Dead time is shorter than one phase, so it only ever falls in phase 0.
  localparam logic [SW-1:0] DEAD_SUB = SW'(DEAD_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

`ifdef SSEG_HEX_DECODE_EN
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      4'hF: seg = 7'h47;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction
`else
  logic hex_unused_s;
  assign hex_unused_s = ^{hex_in, hex_mode};
`endif

  // Scan counters
  logic [SW-1:0] sub_q, sub_d;
  logic [3:0]    phase_q, phase_d;
  logic [IW-1:0] idx_q, idx_d;

  // Pending and active display images
  logic [6:0]            pend_seg_q [NUM_DIGITS];
  logic [6:0]            pend_seg_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] pend_dot_q, pend_dot_d;
  logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d;
  logic                  pend_flag_q, pend_flag_d;
  logic [6:0]            act_seg_q [NUM_DIGITS];
  logic [6:0]            act_seg_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] act_dot_q, act_dot_d;
  logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;
  logic                  apply_q, apply_d;

  // Output registers
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dot_q, dot_d;
  logic                  fd_q, fd_d;
  logic                  ack_q, ack_d;

  logic       frame_wrap_s;
  logic       apply_s;
  logic       anode_on_s;
  logic [6:0] cap_seg_s [NUM_DIGITS];

  // Last clock of the last slot: the prescaler wraps from digit NUM_DIGITS-1.
  assign frame_wrap_s = enable && (sub_q == SUB_LAST) && (phase_q == 4'd15) &&
                        (idx_q == IDX_LAST);
  // Swap at the frame boundary, or straight away while the display is off.
  assign apply_s = pend_flag_q && (frame_wrap_s || !enable);

  // Resolve each digit's segment pattern as it would be captured now.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef SSEG_HEX_DECODE_EN
      cap_seg_s[i] = hex_mode ? hex7(hex_in[4*i +: 4]) : seg_in[7*i +: 7];
`else
      cap_seg_s[i] = seg_in[7*i +: 7];
`endif
    end
  end

  // Next state of the scan counters; held at zero while disabled.
  always_comb begin
    sub_d   = sub_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    if (!enable) begin
      sub_d   = {SW{1'b0}};
      phase_d = 4'd0;
      idx_d   = {IW{1'b0}};
    end else if (sub_q == SUB_LAST) begin
      sub_d = {SW{1'b0}};
      if (phase_q == 4'd15) begin
        phase_d = 4'd0;
        idx_d   = (idx_q == IDX_LAST) ? {IW{1'b0}} : idx_q + IW'(1);
      end else begin
        phase_d = phase_q + 4'd1;
      end
    end else begin
      sub_d = sub_q + SW'(1);
    end
  end

  // Next state of the pending/active buffers and the pending flag.
  always_comb begin
    pend_seg_d   = pend_seg_q;
    pend_dot_d   = pend_dot_q;
    pend_blank_d = pend_blank_q;
    act_seg_d    = act_seg_q;
    act_dot_d    = act_dot_q;
    act_blank_d  = act_blank_q;
    pend_flag_d  = pend_flag_q;
    apply_d      = apply_s;
    if (update_req) begin
      pend_seg_d   = cap_seg_s;
      pend_dot_d   = dots_in;
      pend_blank_d = blank_in;
    end else begin
      pend_seg_d   = pend_seg_q;
    end
    if (apply_s) begin
      // A request landing on the apply cycle goes straight to active.
      if (update_req) begin
        act_seg_d   = cap_seg_s;
        act_dot_d   = dots_in;
        act_blank_d = blank_in;
      end else begin
        act_seg_d   = pend_seg_q;
        act_dot_d   = pend_dot_q;
        act_blank_d = pend_blank_q;
      end
      pend_flag_d = 1'b0;
    end else begin
      pend_flag_d = pend_flag_q | update_req;
    end
  end

  // Anode for the current digit: inside duty, past dead time, not blanked.
  assign anode_on_s = (phase_q <= brightness) &&
                      !((phase_q == 4'd0) && (sub_q < DEAD_SUB)) &&
                      !act_blank_q[idx_q];

  // Next value of the pin registers.
  always_comb begin
    an_d  = {NUM_DIGITS{1'b1}};
    seg_d = 7'h00;
    dot_d = 1'b0;
    fd_d  = frame_wrap_s;
    ack_d = apply_q;
    if (enable) begin
      seg_d = act_seg_q[idx_q];
      dot_d = act_dot_q[idx_q];
      if (anode_on_s) begin
        an_d[idx_q] = 1'b0;
      end else begin
        an_d = {NUM_DIGITS{1'b1}};
      end
    end else begin
      seg_d = 7'h00;
    end
  end

  // Scan counter registers.
  always_ff @(posedge app_clk or posedge app_arst) begin
    if (app_arst) begin
      sub_q   <= {SW{1'b0}};
      phase_q <= 4'd0;
      idx_q   <= {IW{1'b0}};
    end else begin
      sub_q   <= sub_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  // Display buffer registers; reset leaves every digit blank.
  always_ff @(posedge app_clk or posedge app_arst) begin
    if (app_arst) begin
      pend_seg_q   <= '{default: 7'h00};
      pend_dot_q   <= {NUM_DIGITS{1'b0}};
      pend_blank_q <= {NUM_DIGITS{1'b1}};
      pend_flag_q  <= 1'b0;
      act_seg_q    <= '{default: 7'h00};
      act_dot_q    <= {NUM_DIGITS{1'b0}};
      act_blank_q  <= {NUM_DIGITS{1'b1}};
      apply_q      <= 1'b0;
    end else begin
      pend_seg_q   <= pend_seg_d;
      pend_dot_q   <= pend_dot_d;
      pend_blank_q <= pend_blank_d;
      pend_flag_q  <= pend_flag_d;
      act_seg_q    <= act_seg_d;
      act_dot_q    <= act_dot_d;
      act_blank_q  <= act_blank_d;
      apply_q      <= apply_d;
    end
  end

  // Pin registers.
  always_ff @(posedge app_clk or posedge app_arst) begin
    if (app_arst) begin
      an_q  <= {NUM_DIGITS{1'b1}};
      seg_q <= 7'h00;
      dot_q <= 1'b0;
      fd_q  <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dot_q <= dot_d;
      fd_q  <= fd_d;
      ack_q <= ack_d;
    end
  end

  assign AN_out     = an_q;
  assign A_TO_G_out = seg_q;
  assign DOTS_out   = dot_q;
  assign frame_done = fd_q;
  assign update_ack = ack_q;

endmodule
